ta_adc_pack: RTL and testbench

TA_ADC_PACK -- requirements
Module: ta_adc_pack

---
 rtl/ta_adc_pack.sv | 104 ++++++++++
 tb/tb_ta_adc_pack.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ta_adc_pack.sv
// ta_adc_pack: packs multi-channel ADC samples into wide sync-framed words buffered in an overflow-counting FIFO
module ta_adc_pack #(
  parameter int SMP_W = 14,
  parameter int NUM_CH = 2,
  parameter int PACK_N = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int W = NUM_CH*SMP_W*PACK_N,
  localparam int LW = $clog2(FIFO_DEPTH)+1
) (
  input  logic                    clk250,
  input  logic                    rst,
  input  logic                    pack_en,
  input  logic                    adc_valid,
  input  logic                    adc_sync,
  input  logic [NUM_CH*SMP_W-1:0] adc_data,
  input  logic                    msb_first,
  input  logic                    pack_ready,
  output logic [W-1:0]            pack_data,
  output logic                    pack_valid,
  output logic [LW-1:0]           fifo_level,
  output logic                    ovf_flag,
  output logic [15:0]             ovf_cnt
);
  localparam int KW = PACK_N > 1 ? $clog2(PACK_N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, FILL = 2'd2;
  logic [1:0] state_q, state_d;
  logic [KW-1:0] k_q, k_d, slot, pos;
  logic msb_q, msb_d, cap, last, push_q, push_d;
  logic [W-1:0] word_q, word_d, ins;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop, full, wr_en, ovf_ev, arm;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  // Sync restarts the word at slot 0; msb order follows msb_first live during ARM, then holds
  always_comb begin
    arm = state_q == IDLE && pack_en;
    msb_d = state_q == ARM ? msb_first : msb_q;
    cap = pack_en && adc_valid && ((state_q == ARM && adc_sync) || state_q == FILL);
    slot = adc_sync ? '0 : k_q;
    last = slot == KW'(PACK_N-1);
    pos = msb_d ? KW'(PACK_N-1) - slot : slot;
    ins = slot == '0 ? '0 : word_q;
    for (int s = 0; s < PACK_N; s++)
      for (int c = 0; c < NUM_CH; c++)
        if (KW'(s) == pos)
          ins[(s*NUM_CH+c)*SMP_W +: SMP_W] = msb_d ? adc_data[(NUM_CH-1-c)*SMP_W +: SMP_W] : adc_data[c*SMP_W +: SMP_W];
    state_d = !pack_en ? IDLE : state_q == IDLE ? ARM :
              (state_q == FILL || (state_q == ARM && adc_valid && adc_sync)) ? FILL :
              state_q == ARM ? ARM : IDLE;
    k_d = !pack_en ? '0 : cap ? (last ? '0 : slot + 1'b1) : k_q;
    word_d = cap ? ins : word_q;
    push_d = cap && last;
  end
  // Framing state, slot counter, partial word and one-cycle push stage
  always_ff @(posedge clk250 or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      msb_q <= 1'b0;
      word_q <= '0;
      push_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      msb_q <= msb_d;
      word_q <= word_d;
      push_q <= push_d;
    end
  // A push into a full FIFO only lands when the head leaves on the same edge
  always_comb begin
    pack_valid = cnt_q != '0;
    pack_data = pack_valid ? mem[rd_q] : '0;
    pop = pack_valid && pack_ready;
    full = cnt_q == LW'(FIFO_DEPTH);
    wr_en = push_q && (!full || pop);
    ovf_ev = push_q && full && !pop;
    cnt_d = (wr_en && !pop) ? cnt_q + 1'b1 : (pop && !wr_en) ? cnt_q - 1'b1 : cnt_q;
    ovf_d = arm ? 1'b0 : ovf_q || ovf_ev;
    ovf_cnt_d = arm ? '0 : (ovf_ev && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
  end
  // FIFO storage; contents need no reset because the output is gated by the level
  always_ff @(posedge clk250)
    if (wr_en) mem[wr_q] <= word_q;
  // FIFO pointers, level and overflow bookkeeping
  always_ff @(posedge clk250 or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_q <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  assign fifo_level = cnt_q;
  assign ovf_flag = ovf_q;
  assign ovf_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_ta_adc_pack.sv
// tb_ta_adc_pack: directed stimulus against a queue-based reference model of the ADC packer
module tb_ta_adc_pack;
  localparam int SMP_W = 14, NUM_CH = 2, PACK_N = 4, D = 4;
  localparam int SW = NUM_CH*SMP_W, W = SW*PACK_N;
  logic clk250 = 0, rst, pack_en, adc_valid, adc_sync, msb_first, pack_ready;
  logic [SW-1:0] adc_data;
  logic [W-1:0] pack_data;
  logic pack_valid, ovf_flag;
  logic [2:0] fifo_level;
  logic [15:0] ovf_cnt;
  int n_chk = 0, n_fail = 0;

  ta_adc_pack dut (.clk250(clk250), .rst(rst), .pack_en(pack_en), .adc_valid(adc_valid),
    .adc_sync(adc_sync), .adc_data(adc_data), .msb_first(msb_first), .pack_ready(pack_ready),
    .pack_data(pack_data), .pack_valid(pack_valid), .fifo_level(fifo_level),
    .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt));

  always #5 clk250 = ~clk250;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, a frame is the list of samples since the last sync
  logic [W-1:0] q[$];
  logic [SW-1:0] smp[$];
  logic [W-1:0] pend_w = '0, nw;
  bit pend_v = 0, nv, armed = 0, synced = 0, msb_m = 0, m_flag = 0;
  int m_cnt = 0;

  function automatic logic [W-1:0] build(input bit msb);
    logic [W-1:0] w = '0;
    logic [SW-1:0] s;
    for (int k = 0; k < PACK_N; k++) begin
      s = smp[k];
      for (int c = 0; c < NUM_CH; c++) begin
        int e = k*NUM_CH + c;
        if (msb) e = PACK_N*NUM_CH - 1 - e;
        w[e*SMP_W +: SMP_W] = s[c*SMP_W +: SMP_W];
      end
    end
    return w;
  endfunction

  always @(posedge clk250 or posedge rst) begin
    if (rst) begin
      q.delete(); smp.delete();
      pend_v = 0; armed = 0; synced = 0; msb_m = 0; m_flag = 0; m_cnt = 0;
    end else begin
      nv = 0; nw = '0;
      if (q.size() > 0 && pack_ready) void'(q.pop_front());
      if (pend_v) begin
        if (q.size() == D) begin
          m_flag = 1;
          if (m_cnt < 65535) m_cnt++;
        end else q.push_back(pend_w);
      end
      if (!pack_en) begin
        armed = 0; synced = 0; smp.delete();
      end else if (!armed) begin
        armed = 1; m_flag = 0; m_cnt = 0;
      end else begin
        if (!synced) msb_m = msb_first;
        if (adc_valid && adc_sync) begin
          smp.delete(); smp.push_back(adc_data); synced = 1;
        end else if (adc_valid && synced) smp.push_back(adc_data);
        if (smp.size() == PACK_N) begin
          nv = 1; nw = build(msb_m); smp.delete();
        end
      end
      pend_v = nv; pend_w = nw;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk250) begin
    chk("m_valid", pack_valid, q.size() > 0);
    chk("m_data", pack_data, q.size() > 0 ? q[0] : '0);
    chk("m_level", fifo_level, q.size());
    chk("m_ovf_flag", ovf_flag, m_flag);
    chk("m_ovf_cnt", ovf_cnt, m_cnt);
  end

  task automatic tick();
    @(posedge clk250); #1;
  endtask

  task automatic send(input logic s, input logic [13:0] a, input logic [13:0] b);
    adc_valid = 1; adc_sync = s; adc_data = {b, a};
    tick();
    adc_valid = 0; adc_sync = 0;
  endtask

  task automatic word_n(input int i);
    for (int j = 0; j < 4; j++)
      send(j == 0, 14'(256*(i+1) + 2*j), 14'(256*(i+1) + 2*j + 1));
  endtask

  initial begin
    rst = 1; pack_en = 0; adc_valid = 0; adc_sync = 0; adc_data = '0; msb_first = 0; pack_ready = 1;
    tick(); tick();
    chk("rst_valid", pack_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", {ovf_flag, ovf_cnt}, 0);
    rst = 0; pack_en = 1;
    tick();
    send(1, 14'h001, 14'h002); send(0, 14'h003, 14'h004); send(0, 14'h005, 14'h006); send(0, 14'h007, 14'h008);
    chk("lat_pre", pack_valid, 0);
    tick();
    chk("lat_valid", pack_valid, 1);
    chk("lsb_s0c0", pack_data[13:0], 14'h001);
    chk("lsb_s3c1", pack_data[111:98], 14'h008);
    tick();
    chk("lsb_drained", fifo_level, 0);

    pack_en = 0; msb_first = 1; tick();
    pack_en = 1; tick();
    send(1, 14'h001, 14'h002);
    msb_first = 0;
    send(0, 14'h003, 14'h004); send(0, 14'h005, 14'h006); send(0, 14'h007, 14'h008);
    tick();
    chk("msb_valid", pack_valid, 1);
    chk("msb_s0c0", pack_data[111:98], 14'h001);
    chk("msb_s3c1", pack_data[13:0], 14'h008);
    tick();

    pack_en = 0; tick();
    pack_en = 1; tick();
    pack_ready = 0;
    for (int i = 0; i < 6; i++) word_n(i);
    tick(); tick();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_cnt", ovf_cnt, 2);
    chk("ovf_flag", ovf_flag, 1);
    chk("ovf_head", pack_data[13:0], 14'h100);

    word_n(6);
    pack_ready = 1; tick(); pack_ready = 0;
    chk("pp_level", fifo_level, 4);
    chk("pp_cnt", ovf_cnt, 2);
    chk("pp_head", pack_data[13:0], 14'h200);
    pack_ready = 1;
    repeat (5) tick();
    chk("drain_level", fifo_level, 0);

    send(1, 14'h010, 14'h011); send(0, 14'h012, 14'h013);
    send(1, 14'h020, 14'h021); send(0, 14'h022, 14'h023); send(0, 14'h024, 14'h025); send(0, 14'h026, 14'h027);
    tick();
    chk("rs_valid", pack_valid, 1);
    chk("rs_s0c0", pack_data[13:0], 14'h020);
    chk("rs_s1c0", pack_data[41:28], 14'h022);
    repeat (3) tick();
    chk("rs_no_extra", pack_valid, 0);

    pack_ready = 0;
    word_n(0); word_n(1);
    tick();
    chk("pre_rst_level", fifo_level, 2);
    send(1, 14'h030, 14'h031); send(0, 14'h032, 14'h033);
    #2 rst = 1;
    #1;
    chk("arst_valid", pack_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_data", pack_data, 0);
    chk("arst_ovf", {ovf_flag, ovf_cnt}, 0);
    #2 rst = 0;
    tick();
    for (int j = 0; j < 4; j++) send(0, 14'(j), 14'(j + 1));
    repeat (2) tick();
    chk("nosync_level", fifo_level, 0);
    word_n(2);
    tick();
    chk("resync_level", fifo_level, 1);
    chk("resync_head", pack_data[13:0], 14'h300);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
